// File: rtl/freq_meter_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | freq_meter_ctrl : gate-time sequencer for a 4-digit BCD frequency counter   |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module freq_meter_ctrl #(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int HOLD_CYCLES = 25_000_000,
  parameter int TW          = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        continuous,
  input  logic        stop,
  input  logic        sig_in,
  input  logic [15:0] cnt_val,
  output logic        cnt_clr,
  output logic        cnt_en,
  output logic [15:0] result,
  output logic        valid,
  output logic        ovf,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_SETTLE = 3'd2,
    S_GATE   = 3'd3,
    S_LATCH  = 3'd4,
    S_HOLD   = 3'd5
  } state_t;

  localparam logic [TW-1:0] c_gate_load = TW'(GATE_CYCLES - 1);
  localparam logic [TW-1:0] c_hold_load = TW'(HOLD_CYCLES - 1);
  localparam logic [15:0]   c_bcd_max   = 16'h9999;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            sync1_q, sync2_q, sync3_q;
  logic            cnt_en_q, cnt_en_d;
  logic            cnt_clr_q, cnt_clr_d;
  logic            valid_q, valid_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     result_q, result_d;

  logic            w_edge;
  logic            w_sat;
  logic            w_gate_next;

  assign w_edge      = sync2_q & ~sync3_q;
  assign w_sat       = (cnt_val == c_bcd_max);
  assign w_gate_next = (state_d == S_GATE);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_CLEAR;
      S_CLEAR:  state_d = S_SETTLE;
      S_SETTLE: begin
        state_d = S_GATE;
        timer_d = c_gate_load;
      end
      S_GATE: begin
        if (timer_q == '0) state_d = S_LATCH;
        else               timer_d = timer_q - TW'(1);
      end
      S_LATCH: begin
        state_d = S_HOLD;
        timer_d = c_hold_load;
      end
      S_HOLD: begin
        if (timer_q == '0) state_d = continuous ? S_CLEAR : S_IDLE;
        else               timer_d = timer_q - TW'(1);
      end
      default: state_d = S_IDLE;
    endcase
    if (stop) state_d = S_IDLE;
  end

  // The enable is registered, so an edge is forwarded only when the cycle
  // that carries its enable is itself a gate cycle. This keeps cnt_en out
  // of LATCH and makes the last gate increment visible during LATCH.
  always_comb begin
    cnt_en_d  = w_gate_next & w_edge & ~w_sat;
    cnt_clr_d = (state_d == S_CLEAR);
    valid_d   = (state_q == S_LATCH) & ~stop;
    result_d  = valid_d ? cnt_val : result_q;
    ovf_d     = ovf_q;
    if ((state_q == S_CLEAR) && !stop) ovf_d = 1'b0;
    if (w_gate_next && w_edge && w_sat) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      sync3_q   <= 1'b0;
      cnt_en_q  <= 1'b0;
      cnt_clr_q <= 1'b0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      result_q  <= 16'h0000;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      sync1_q   <= sig_in;
      sync2_q   <= sync1_q;
      sync3_q   <= sync2_q;
      cnt_en_q  <= cnt_en_d;
      cnt_clr_q <= cnt_clr_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      result_q  <= result_d;
    end
  end

  assign cnt_en  = cnt_en_q;
  assign cnt_clr = cnt_clr_q;
  assign valid   = valid_q;
  assign ovf     = ovf_q;
  assign result  = result_q;
  assign busy    = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_freq_meter_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_freq_meter_ctrl : bench for freq_meter_ctrl with an attached BCD counter |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module tb_freq_meter_ctrl;
  localparam int G    = 100;
  localparam int H    = 20;
  localparam int LAST = G + H + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, continuous = 1'b0, stop = 1'b0, pl = 1'b0;
  logic        per_en = 1'b0, sig_gen = 1'b0, sig_man = 1'b0;
  int          per = 10;
  logic        sig_in;
  logic [15:0] cnt_val;
  logic        cnt_clr, cnt_en, valid, ovf, busy;
  logic [15:0] result;

  int n_chk = 0, n_pass = 0;
  int n_valid = 0, n_en = 0, n_clr = 0;

  assign sig_in = per_en ? sig_gen : sig_man;
  always #5 clk = ~clk;

  freq_meter_ctrl #(.GATE_CYCLES(G), .HOLD_CYCLES(H), .TW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .stop(stop),
    .sig_in(sig_in), .cnt_val(cnt_val), .cnt_clr(cnt_clr), .cnt_en(cnt_en),
    .result(result), .valid(valid), .ovf(ovf), .busy(busy)
  );

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    bit c;
    r = v;
    c = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (c) begin
        if (r[d*4 +: 4] == 4'd9) r[d*4 +: 4] = 4'd0;
        else begin
          r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  // Real 4-digit BCD counter; pl overrides the clear to emulate a preload.
  always @(posedge clk or negedge rst) begin
    if (!rst)         cnt_val <= 16'h0000;
    else if (pl)      cnt_val <= 16'h9995;
    else if (cnt_clr) cnt_val <= 16'h0000;
    else if (cnt_en)  cnt_val <= bcd_inc(cnt_val);
  end

  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      if (per_en) begin
        ph = (ph + 1) % per;
        sig_gen = (ph >= per - per / 2);
      end else begin
        ph = 0;
        sig_gen = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Timeline model: a measurement is a run of phases counted from CLEAR
  // (0 clear, 1 settle, 2..G+1 gate, G+2 latch, G+3..LAST hold). A rise of
  // sig_in driven in cycle n yields an enable in cycle n+3.
  int          k = 0;
  int          m_ph = 0, m_cnt = 0;
  bit          m_act = 0, m_ovf = 0;
  logic [15:0] m_res = 16'h0000;
  bit          e_en = 0, e_clr = 0, e_valid = 0, gate, rise;
  bit          p_rst = 0, p_start = 0, p_stop = 0, p_cont = 0, p_pl = 0, p_en = 0, p_clr = 0;
  bit          sig_log [0:8191];

  always @(negedge clk) begin
    if (!rst || !p_rst) begin
      m_act = 0; m_ph = 0; m_cnt = 0; m_ovf = 0; m_res = 16'h0000;
      e_en = 0; e_clr = 0; e_valid = 0;
    end else begin
      if (p_pl)       m_cnt = 9995;
      else if (p_clr) m_cnt = 0;
      else if (p_en)  m_cnt = (m_cnt + 1) % 10000;
      if (m_act) begin
        if (p_stop) m_act = 0;
        else if (m_ph == LAST) begin
          if (p_cont) m_ph = 0;
          else        m_act = 0;
        end else m_ph++;
      end else if (p_start && !p_stop) begin
        m_act = 1;
        m_ph  = 0;
      end
      gate  = m_act && (m_ph >= 2) && (m_ph <= G + 1);
      rise  = (k >= 4) && (k < 8192) && sig_log[k-3] && !sig_log[k-4];
      e_clr = m_act && (m_ph == 0);
      e_en  = gate && rise && (m_cnt != 9999);
      if (gate && rise && m_cnt == 9999) m_ovf = 1;
      if (m_act && m_ph == 1) m_ovf = 0;
      e_valid = m_act && (m_ph == G + 3);
      if (e_valid) m_res = to_bcd(m_cnt);
    end
    chk("busy",    32'(busy),    32'(m_act));
    chk("cnt_clr", 32'(cnt_clr), 32'(e_clr));
    chk("cnt_en",  32'(cnt_en),  32'(e_en));
    chk("valid",   32'(valid),   32'(e_valid));
    chk("result",  32'(result),  32'(m_res));
    chk("ovf",     32'(ovf),     32'(m_ovf));
    if (valid)   n_valid++;
    if (cnt_en)  n_en++;
    if (cnt_clr) n_clr++;
    p_rst = rst; p_start = start; p_stop = stop; p_cont = continuous; p_pl = pl;
    p_en = e_en; p_clr = e_clr;
    if (k < 8192) sig_log[k] = sig_in;
    k++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while (busy && c < budget) begin
      tick(1);
      c++;
    end
    chk("idle_within_budget", 32'(busy), 32'd0);
  endtask

  initial begin
    int v0, e0, c0, c;
    tick(3);
    rst = 1'b1;
    tick(3);
    chk("reset_result", 32'(result), 32'h0);
    chk("reset_busy",   32'(busy),   32'h0);

    // 1: period 10, single shot
    per = 10; per_en = 1'b1; tick(5);
    v0 = n_valid;
    pulse_start();
    wait_idle(300);
    chk("s1_valid_count", 32'(n_valid - v0), 32'd1);
    chk("s1_result",      32'(result),       32'h0010);
    chk("s1_ovf",         32'(ovf),          32'd0);

    // 5: stop at gate cycle 50
    tick(5);
    v0 = n_valid;
    pulse_start();
    tick(51);
    stop = 1'b1;
    tick(1);
    chk("s5_idle_after_stop", 32'(busy), 32'd0);
    stop = 1'b0;
    tick(5);
    chk("s5_no_valid", 32'(n_valid - v0), 32'd0);
    chk("s5_result",   32'(result),       32'h0010);

    // 2: no input activity
    per_en = 1'b0; tick(5);
    v0 = n_valid; e0 = n_en;
    pulse_start();
    wait_idle(300);
    chk("s2_result",      32'(result),       32'h0000);
    chk("s2_valid_count", 32'(n_valid - v0), 32'd1);
    chk("s2_no_enable",   32'(n_en - e0),    32'd0);

    // 3: preload 9995, period 4 -> saturate
    per = 4; per_en = 1'b1; tick(5);
    start = 1'b1;
    tick(1);
    start = 1'b0; pl = 1'b1;
    tick(1);
    pl = 1'b0;
    wait_idle(300);
    chk("s3_result",  32'(result),  32'h9999);
    chk("s3_ovf",     32'(ovf),     32'd1);
    chk("s3_counter", 32'(cnt_val), 32'h9999);

    // 4: continuous, period 5
    per = 5; continuous = 1'b1; tick(5);
    v0 = n_valid; c0 = n_clr;
    pulse_start();
    c = 0;
    while ((n_valid - v0) < 3 && c < 600) begin
      tick(1);
      c++;
    end
    continuous = 1'b0;
    wait_idle(300);
    chk("s4_valid_count", 32'(n_valid - v0), 32'd3);
    chk("s4_clr_count",   32'(n_clr - c0),   32'd3);
    chk("s4_result",      32'(result),       32'h0020);
    chk("s4_ovf",         32'(ovf),          32'd0);

    // 6: reset mid-gate, then a normal run
    per = 10; tick(5);
    pulse_start();
    tick(40);
    rst = 1'b0;
    #1;
    chk("s6_rst_result",  32'(result),  32'h0);
    chk("s6_rst_busy",    32'(busy),    32'h0);
    chk("s6_rst_cnt_en",  32'(cnt_en),  32'h0);
    chk("s6_rst_cnt_clr", 32'(cnt_clr), 32'h0);
    chk("s6_rst_valid",   32'(valid),   32'h0);
    chk("s6_rst_ovf",     32'(ovf),     32'h0);
    tick(2);
    rst = 1'b1;
    tick(5);
    pulse_start();
    wait_idle(300);
    chk("s6_result_after", 32'(result), 32'h0010);

    // Edges whose enable lands in the first and last gate cycles count.
    per_en = 1'b0; sig_man = 1'b0; tick(5);
    start = 1'b1; sig_man = 1'b1;
    tick(1);
    start = 1'b0; sig_man = 1'b0;
    tick(98);
    sig_man = 1'b1;
    tick(1);
    sig_man = 1'b0;
    wait_idle(300);
    chk("gate_ends_result", 32'(result), 32'h0002);

    // Edges landing in SETTLE and LATCH are dropped.
    tick(5);
    sig_man = 1'b1;
    tick(1);
    sig_man = 1'b0; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(99);
    sig_man = 1'b1;
    tick(1);
    sig_man = 1'b0;
    wait_idle(300);
    chk("settle_latch_result", 32'(result), 32'h0000);

    tick(3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
